// File: rtl/mult_hilo_unit_pkg.sv
// Shared opcode constants (SignaltoMUL codes) and FSM encoding for the HI/LO multiplier.
// The upstream ALU control stage decodes to the same opcode values.
package mult_hilo_unit_pkg;

  localparam logic [5:0] MULT      = 6'b011001;
  localparam logic [5:0] MFHI      = 6'b010000;
  localparam logic [5:0] MFLO      = 6'b010010;
  localparam logic [5:0] HILO_OPEN = 6'b111111;

  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  function automatic logic is_read_op(input logic [5:0] code);
    return (code == MFHI) || (code == MFLO);
  endfunction

endpackage

// File: rtl/mult_hilo_unit_hilo_reg.sv
// HI/LO result pair: loads a full product on commit_en, and muxes HI or LO onto
// data_out combinationally for MFHI/MFLO (zero otherwise).
module mult_hilo_unit_hilo_reg
  import mult_hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               commit_en,
  input  logic [2*WIDTH-1:0] prod_in,
  input  logic [5:0]         signal_in,
  output logic [WIDTH-1:0]   data_out
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit_en) begin
      hi_d = prod_in[2*WIDTH-1:WIDTH];
      lo_d = prod_in[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    data_out = '0;
    if (is_read_op(signal_in)) begin
      data_out = (signal_in == MFHI) ? hi_q : lo_q;
    end
  end

endmodule

// File: rtl/mult_hilo_unit.sv
// Sequential unsigned shift-add multiplier: one add/shift step per clock for ITER
// cycles, product held in DONE until HILO_OPEN commits it into the HI/LO pair.
module mult_hilo_unit
  import mult_hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             prod_ready
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   iter_cnt_q, iter_cnt_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               commit;
  logic [WIDTH:0]     upper_sum;

  // Carry out of the upper half is kept so the shifted word never loses a bit.
  always_comb begin
    upper_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]};
    if (work_q[0]) begin
      upper_sum = {1'b0, work_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end
  end

  always_comb begin
    state_d    = state_q;
    iter_cnt_d = iter_cnt_q;
    work_d     = work_q;
    mcand_d    = mcand_q;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Signal == MULT) begin
          state_d    = ST_RUN;
          mcand_d    = dataA;
          work_d     = {{WIDTH{1'b0}}, dataB};
          iter_cnt_d = '0;
        end
      end
      ST_RUN: begin
        work_d     = {upper_sum, work_q[WIDTH-1:1]};
        iter_cnt_d = iter_cnt_q + CNT_W'(1);
        if (iter_cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (Signal == HILO_OPEN) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end else if (Signal == MULT) begin
          state_d    = ST_RUN;
          mcand_d    = dataA;
          work_d     = {{WIDTH{1'b0}}, dataB};
          iter_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      iter_cnt_q <= '0;
      work_q     <= '0;
      mcand_q    <= '0;
    end else begin
      state_q    <= state_d;
      iter_cnt_q <= iter_cnt_d;
      work_q     <= work_d;
      mcand_q    <= mcand_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign prod_ready = (state_q == ST_DONE);

  mult_hilo_unit_hilo_reg #(
    .WIDTH(WIDTH)
  ) u_hilo_reg (
    .clk       (clk),
    .reset     (reset),
    .commit_en (commit),
    .prod_in   (work_q),
    .signal_in (Signal),
    .data_out  (dataOut)
  );

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Bench for mult_hilo_unit: drives MULT/HILO_OPEN sequences, keeps expected products
// in a queue and compares committed HI/LO read back through MFHI/MFLO.
module tb_mult_hilo_unit;
  import mult_hilo_unit_pkg::*;

  localparam int W = 32;

  localparam int MODE_NORMAL   = 0;
  localparam int MODE_EARLY    = 1;
  localparam int MODE_RESET    = 2;
  localparam int MODE_SCRAMBLE = 3;
  localparam int MODE_NOCOMMIT = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [5:0]   sig = 6'd0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic [W-1:0] data_out;
  logic         busy;
  logic         prod_ready;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   hi_m = '0;
  logic [W-1:0]   lo_m = '0;
  int             n_tests = 0;
  int             n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  mult_hilo_unit #(.WIDTH(W), .ITER(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .Signal     (sig),
    .dataA      (a_in),
    .dataB      (b_in),
    .dataOut    (data_out),
    .busy       (busy),
    .prod_ready (prod_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; both reads settle well before the next rising edge.
  task automatic read_hilo(input string tag);
    sig = MFLO;
    #1;
    check({tag, "_lo"}, 64'(data_out), 64'(lo_m));
    sig = MFHI;
    #1;
    check({tag, "_hi"}, 64'(data_out), 64'(hi_m));
  endtask

  task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input int mode);
    int busy_cnt;
    bit finished;
    bit aborted;
    logic [2*W-1:0] exp_p;
    busy_cnt = 0;
    finished = 1'b0;
    aborted  = 1'b0;
    @(negedge clk);
    sig  = MULT;
    a_in = a;
    b_in = b;
    exp_q.push_back(64'(a) * 64'(b));
    @(posedge clk);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (reset == 1'b0) begin
        reset = 1'b1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_ready", 64'(prod_ready), 64'(0));
        hi_m = '0;
        lo_m = '0;
        read_hilo("rst_mid");
        void'(exp_q.pop_back());
        aborted = 1'b1;
        break;
      end
      if (!busy) begin
        finished = 1'b1;
        break;
      end
      busy_cnt++;
      sig = MULT;
      if (mode == MODE_SCRAMBLE) begin
        a_in = $urandom;
        b_in = $urandom;
      end
      if (mode == MODE_EARLY && busy_cnt == 10) sig = HILO_OPEN;
      if (mode == MODE_RESET && busy_cnt == 17) reset = 1'b0;
    end
    if (aborted) return;
    if (!finished) begin
      check("run_timeout", 64'(busy_cnt), 64'(32));
      return;
    end
    check("busy_cycles", 64'(busy_cnt), 64'(32));
    check("prod_ready", 64'(prod_ready), 64'(1));
    read_hilo("pre_commit");
    if (mode == MODE_NOCOMMIT) begin
      void'(exp_q.pop_front());
      return;
    end
    sig = HILO_OPEN;
    @(posedge clk);
    @(negedge clk);
    check("post_busy", 64'(busy), 64'(0));
    check("post_ready", 64'(prod_ready), 64'(0));
    if (exp_q.size() == 0) begin
      check("queue_empty", 64'(1), 64'(0));
      return;
    end
    exp_p = exp_q.pop_front();
    hi_m  = exp_p[2*W-1:W];
    lo_m  = exp_p[W-1:0];
    read_hilo("commit");
  endtask

  initial begin
    reset = 1'b0;
    sig   = 6'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_ready", 64'(prod_ready), 64'(0));
    read_hilo("reset");
    reset = 1'b1;

    run_mult(32'd3, 32'd5, MODE_NORMAL);
    check("basic_lo_const", 64'(lo_m), 64'd15);

    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, MODE_NORMAL);
    check("max_hi_const", 64'(hi_m), 64'hFFFF_FFFE);
    check("max_lo_const", 64'(lo_m), 64'h0000_0001);

    run_mult(32'd3, 32'd5, MODE_NORMAL);
    run_mult(32'd9, 32'd11, MODE_EARLY);

    run_mult(32'd123, 32'd456, MODE_RESET);
    run_mult(32'd7, 32'd6, MODE_NORMAL);
    check("fresh_lo_const", 64'(lo_m), 64'd42);

    // Non-read codes must leave the result bus at zero.
    @(negedge clk);
    sig = 6'd0;
    #1;
    check("other_code", 64'(data_out), 64'(0));
    // HILO_OPEN while idle must not disturb HI/LO.
    sig = HILO_OPEN;
    @(posedge clk);
    @(negedge clk);
    read_hilo("idle_open");

    run_mult(32'd2, 32'd2, MODE_NOCOMMIT);
    run_mult(32'd10, 32'd10, MODE_NORMAL);
    check("restart_lo_const", 64'(lo_m), 64'd100);

    run_mult(32'hDEAD_BEEF, 32'h1234_5678, MODE_SCRAMBLE);
    for (int k = 0; k < 3; k++) begin
      run_mult($urandom, $urandom, MODE_NORMAL);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
- Sequential 32x32 unsigned shift-add multiplier with HI/LO result registers.
- Sits directly downstream of the ALU control stage and consumes its SignaltoMUL code (MULT, MFHI, MFLO, HILO_OPEN = 6'b111111).
- Runs one add/shift iteration per clock for 32 cycles.
- Commits the 64-bit product to HI/LO only on the HILO_OPEN strobe, and drives HI or LO onto the result bus for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, the product is 2*WIDTH bits.
- ITER, 32, iteration count; must equal WIDTH and match the control-stage MULT count.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset), sampled on the rising edge of clk.
- Signal  input  6  function code from the control stage's SignaltoMUL.
- dataA  input  WIDTH  multiplicand, sampled at start.
- dataB  input  WIDTH  multiplier, sampled at start.
- dataOut  output  WIDTH  HI when Signal==MFHI, LO when Signal==MFLO, otherwise 0.
- busy  output  1  high while iterating (RUN state).
- prod_ready  output  1  high while a finished, uncommitted product is held (DONE state).

Behaviour:
- Reset (reset==0 at a rising clk edge): state=IDLE, iter_cnt=0, work product=0, multiplicand reg=0, HI=0, LO=0; busy=0, prod_ready=0, dataOut=0. Reset overrides everything, including a run in progress; the partial product is discarded and HI/LO are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when Signal==MULT. On that edge:
  - multiplicand reg <= dataA;
  - work <= {WIDTH'b0, dataB};
  - iter_cnt <= 0.
- RUN, each cycle:
  - if work[0]==1, upper = work[2W-1:W] + multiplicand, computed at WIDTH+1 bits keeping the carry;
  - work <= {carry, upper, work[W-1:1]}, i.e. a logical right shift of the 2W+1-bit sum;
  - iter_cnt <= iter_cnt+1.
- RUN -> DONE on the edge where iter_cnt==ITER-1, so RUN lasts exactly ITER cycles. work then holds dataA*dataB exactly; unsigned, no overflow possible in 2W bits.
- In RUN, Signal is ignored: operands are not re-sampled, and MULT or HILO_OPEN have no effect. dataA/dataB changes after start do not affect the result.
- DONE:
  - Signal==HILO_OPEN: HI <= work[2W-1:W], LO <= work[W-1:0], -> IDLE. HI/LO are visible on dataOut from the next cycle.
  - Signal==MULT: restart exactly as from IDLE; the uncommitted product is discarded and HI/LO are unchanged.
  - Anything else: hold in DONE.
- HILO_OPEN in IDLE or RUN: no effect; HI/LO are unchanged.
- dataOut is combinational from Signal and the registered HI/LO, with zero latency, in every state. During RUN it still reflects the previously committed HI/LO.
- busy = (state==RUN); prod_ready = (state==DONE). Both are registered-state decodes with no glitch paths from Signal.
- Timing: if MULT is first seen at edge T0, the result is ready from edge T0+ITER. That is the same edge the control stage emits HILO_OPEN for one cycle, so the commit happens at edge T0+ITER+1.

Decomposition:
- Shared package: opcode constants MULT=6'b011001, MFHI=6'b010000, MFLO=6'b010010, HILO_OPEN=6'b111111, plus the FSM state encoding. The control stage references the same constants.
- One natural sub-module: hilo_reg, holding the HI/LO pair with a commit enable and MFHI/MFLO read mux. Datapath and FSM stay in the top.

Test Plan:
- Basic multiply: reset, then dataA=3, dataB=5, hold Signal=MULT for 32 cycles, then HILO_OPEN for 1 cycle -> busy high exactly 32 cycles; after commit, MFLO gives 15 and MFHI gives 0.
- Max operands: dataA=dataB=32'hFFFFFFFF, same sequence -> MFHI=32'hFFFFFFFE, MFLO=32'h00000001, confirming the carry bit is kept.
- Early strobe: HILO_OPEN pulsed at RUN cycle 10 -> HI/LO keep their prior values (e.g. 0/15); a commit only occurs on a later HILO_OPEN in DONE.
- Reset mid-run: reset=0 for one edge at RUN cycle 17 -> next cycle state=IDLE, busy=0, MFHI=MFLO=0; a fresh 7*6 run then yields LO=42.
- Restart in DONE: after finishing 2*2, present MULT with dataA=10, dataB=10 instead of HILO_OPEN -> HI/LO stay at their prior values, a new 32-cycle run occurs, and HILO_OPEN then commits LO=100.
- Operand stability: change dataA/dataB every cycle during RUN -> the result equals the product of the values sampled at start.
